// File: rtl/uc_intr.sv
// uc_intr: CPU control unit with a small interrupt sequencer.
//
// Decodes the 6-bit opcode into datapath controls (combinational in RUN) and
// sequences N_INTR prioritised, edge-triggered interrupt channels through a
// one-cycle TAKE state that pushes the PC and loads the handler vector.
// Channel 0 has the highest priority. HALT parks the PC until an interrupt
// is taken, or until reset.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   opcode, z             instruction opcode and registered zero flag
//   intr_req[N_INTR]      level request lines; a rising edge raises a request
//   s_inc .. s_return_intr, op_alu
//                         datapath controls (base decoder meanings)
//   s_vector, vector_addr PC loads the handler vector during TAKE
//   intr_ack[N_INTR]      one-hot acknowledge, TAKE cycle only
//   ie, in_service, halted
//                         registered sequencer status
module uc_intr #(
    parameter int unsigned       N_INTR     = 4,
    parameter int unsigned       VEC_W      = 10,
    parameter logic [VEC_W-1:0]  VEC_BASE   = 10'h3C0,
    parameter int unsigned       VEC_STRIDE = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        opcode,
    input  logic              z,
    input  logic [N_INTR-1:0] intr_req,
    output logic              s_inc,
    output logic              s_inm,
    output logic              s_mux_datos,
    output logic              we3,
    output logic              wez,
    output logic              s_stack_mux,
    output logic              push,
    output logic              pop,
    output logic              s_return_intr,
    output logic [2:0]        op_alu,
    output logic              s_vector,
    output logic [VEC_W-1:0]  vector_addr,
    output logic [N_INTR-1:0] intr_ack,
    output logic              ie,
    output logic              in_service,
    output logic              halted
);

    localparam int unsigned IDX_W = (N_INTR > 1) ? $clog2(N_INTR) : 1;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_TAKE = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]        state, state_next;
    logic [N_INTR-1:0] pending, req_q, sel, clr;
    logic [IDX_W-1:0]  idx;
    logic              ie_next, in_service_next, take, halt_op;

    // Lowest set pending bit wins: scan from the top so lower indices overwrite.
    always_comb begin
        idx = '0;
        for (int unsigned i = N_INTR; i > 0; i--) begin
            if (pending[i-1]) idx = IDX_W'(i - 1);
        end
    end

    assign sel = N_INTR'(1) << idx;

    always_comb begin
        s_inc           = 1'b0;
        s_inm           = 1'b0;
        s_mux_datos     = 1'b0;
        we3             = 1'b0;
        wez             = 1'b0;
        s_stack_mux     = 1'b0;
        push            = 1'b0;
        pop             = 1'b0;
        s_return_intr   = 1'b0;
        op_alu          = 3'b000;
        s_vector        = 1'b0;
        intr_ack        = '0;
        clr             = '0;
        halt_op         = 1'b0;
        take            = 1'b0;
        ie_next         = ie;
        in_service_next = in_service;
        state_next      = ST_RUN;

        case (state)
            ST_RUN: begin
                casez (opcode)
                    6'b111111: begin
                        s_inc   = 1'b1;
                        halt_op = 1'b1;
                    end
                    6'b1?????: begin
                        s_inc = 1'b1;
                        if (opcode[4:2] != 3'b111) begin
                            s_inm  = 1'b1;
                            we3    = 1'b1;
                            wez    = 1'b1;
                            op_alu = opcode[4:2];
                        end
                    end
                    6'b010???: begin
                        s_inc = 1'b1;
                        if (opcode[2:0] != 3'b111) begin
                            we3    = 1'b1;
                            wez    = 1'b1;
                            op_alu = (opcode[2:0] == 3'b110) ? 3'b111 : opcode[2:0];
                        end
                    end
                    6'b001000: s_inc = 1'b0;
                    6'b001001: s_inc = ~z;
                    6'b001010: s_inc = z;
                    6'b001011: push  = 1'b1;
                    6'b001100: begin
                        pop         = 1'b1;
                        s_stack_mux = 1'b1;
                    end
                    6'b001101: begin
                        pop             = 1'b1;
                        s_stack_mux     = 1'b1;
                        s_return_intr   = 1'b1;
                        ie_next         = 1'b1;
                        in_service_next = 1'b0;
                    end
                    6'b000001: begin
                        s_inc   = 1'b1;
                        ie_next = 1'b1;
                    end
                    6'b000010: begin
                        s_inc   = 1'b1;
                        ie_next = 1'b0;
                    end
                    default: s_inc = 1'b1;
                endcase
                // The enable seen by take already includes this instruction's EI/DI/RETI.
                take = ie_next & ~in_service & (|pending);
                if (take)         state_next = ST_TAKE;
                else if (halt_op) state_next = ST_HALT;
                else              state_next = ST_RUN;
            end
            ST_TAKE: begin
                push            = 1'b1;
                s_vector        = 1'b1;
                intr_ack        = sel;
                clr             = sel;
                ie_next         = 1'b0;
                in_service_next = 1'b1;
                state_next      = ST_RUN;
            end
            ST_HALT: begin
                take       = ie & ~in_service & (|pending);
                state_next = take ? ST_TAKE : ST_HALT;
            end
            default: state_next = ST_RUN;
        endcase

        // Decode is combinational on opcode, so force every output quiet in reset.
        if (!reset) begin
            s_inc         = 1'b0;
            s_inm         = 1'b0;
            we3           = 1'b0;
            wez           = 1'b0;
            s_stack_mux   = 1'b0;
            push          = 1'b0;
            pop           = 1'b0;
            s_return_intr = 1'b0;
            op_alu        = 3'b000;
            s_vector      = 1'b0;
            intr_ack      = '0;
        end
    end

    always_comb begin
        vector_addr = '0;
        if (reset && (|pending))
            vector_addr = VEC_BASE + VEC_W'(32'(idx) * VEC_STRIDE);
    end

    assign halted = (state == ST_HALT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_RUN;
            pending    <= '0;
            req_q      <= '0;
            ie         <= 1'b0;
            in_service <= 1'b0;
        end else begin
            state      <= state_next;
            req_q      <= intr_req;
            // A new edge on the channel being acknowledged survives the clear.
            pending    <= (pending & ~clr) | (intr_req & ~req_q);
            ie         <= ie_next;
            in_service <= in_service_next;
        end
    end

endmodule

// File: tb/tb_uc_intr.sv
// Testbench for uc_intr: directed vectors with hand-computed expectations.
// The stimulus process pushes the expected outputs for a cycle into a queue;
// a monitor on the falling edge pops and compares entries tagged with the
// current cycle.
module tb_uc_intr;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       s_mux_datos;
        logic       we3;
        logic       wez;
        logic       s_stack_mux;
        logic       push;
        logic       pop;
        logic       s_return_intr;
        logic [2:0] op_alu;
        logic       s_vector;
        logic [9:0] vector_addr;
        logic [3:0] intr_ack;
        logic       ie;
        logic       in_service;
        logic       halted;
    } obs_t;

    typedef struct {
        int    cyc;
        string nm;
        obs_t  e;
        obs_t  m;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = '0;
    logic       z = 1'b0;
    logic [3:0] intr_req = '0;
    logic       s_inc, s_inm, s_mux_datos, we3, wez, s_stack_mux, push, pop, s_return_intr;
    logic [2:0] op_alu;
    logic       s_vector;
    logic [9:0] vector_addr;
    logic [3:0] intr_ack;
    logic       ie, in_service, halted;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    ent_t q[$];
    obs_t o;

    uc_intr #(
        .N_INTR    (4),
        .VEC_W     (10),
        .VEC_BASE  (10'h3C0),
        .VEC_STRIDE(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .z            (z),
        .intr_req     (intr_req),
        .s_inc        (s_inc),
        .s_inm        (s_inm),
        .s_mux_datos  (s_mux_datos),
        .we3          (we3),
        .wez          (wez),
        .s_stack_mux  (s_stack_mux),
        .push         (push),
        .pop          (pop),
        .s_return_intr(s_return_intr),
        .op_alu       (op_alu),
        .s_vector     (s_vector),
        .vector_addr  (vector_addr),
        .intr_ack     (intr_ack),
        .ie           (ie),
        .in_service   (in_service),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign o = {s_inc, s_inm, s_mux_datos, we3, wez, s_stack_mux, push, pop,
                s_return_intr, op_alu, s_vector, vector_addr, intr_ack,
                ie, in_service, halted};

    // Monitor: compare every expectation queued for this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            ent_t t;
            t = q.pop_front();
            checks = checks + 1;
            if (t.cyc != cyc || ((o & t.m) != (t.e & t.m))) begin
                errors = errors + 1;
                $display("FAIL %s cyc=%0d got=%h exp=%h mask=%h", t.nm, cyc, o, t.e, t.m);
            end
        end
    end

    function automatic obs_t st(input logic i_e, input logic i_s, input logic h);
        obs_t r;
        r = '0;
        r.ie = i_e;
        r.in_service = i_s;
        r.halted = h;
        return r;
    endfunction

    function automatic obs_t nop(input logic i_e, input logic i_s);
        obs_t r;
        r = st(i_e, i_s, 1'b0);
        r.s_inc = 1'b1;
        return r;
    endfunction

    function automatic obs_t tk(input logic [3:0] ack, input logic [9:0] va);
        obs_t r;
        r = st(1'b1, 1'b0, 1'b0);
        r.push = 1'b1;
        r.s_vector = 1'b1;
        r.intr_ack = ack;
        r.vector_addr = va;
        return r;
    endfunction

    task automatic step(input logic rst, input logic [5:0] op, input logic zz,
                        input logic [3:0] req, input string nm, input obs_t e,
                        input bit vchk);
        ent_t t;
        @(posedge clk);
        #1;
        reset = rst;
        opcode = op;
        z = zz;
        intr_req = req;
        t.cyc = cyc;
        t.nm = nm;
        t.e = e;
        t.m = '1;
        if (!vchk) t.m.vector_addr = '0;
        q.push_back(t);
    endtask

    initial begin
        obs_t e;

        // Reset: outputs quiet even with a live ALU opcode.
        step(0, 6'b010010, 0, 4'h0, "reset", st(0, 0, 0), 1);
        step(0, 6'b010010, 0, 4'h0, "reset2", st(0, 0, 0), 1);

        e = nop(0, 0); e.we3 = 1; e.wez = 1; e.op_alu = 3'b010;
        step(1, 6'b010010, 0, 4'h0, "alu_reg", e, 1);
        e = nop(0, 0); e.we3 = 1; e.wez = 1; e.op_alu = 3'b111;
        step(1, 6'b010110, 0, 4'h0, "alu_110", e, 0);
        e = nop(0, 0); e.s_inm = 1; e.we3 = 1; e.wez = 1; e.op_alu = 3'b011;
        step(1, 6'b101101, 0, 4'h0, "alu_imm", e, 0);
        step(1, 6'b010111, 0, 4'h0, "nop_010111", nop(0, 0), 0);
        step(1, 6'b111100, 0, 4'h0, "nop_111100", nop(0, 0), 0);
        step(1, 6'b001001, 1, 4'h0, "jz_z1", st(0, 0, 0), 0);
        step(1, 6'b001001, 0, 4'h0, "jz_z0", nop(0, 0), 0);
        e = st(0, 0, 0); e.push = 1;
        step(1, 6'b001011, 0, 4'h0, "jal", e, 0);
        step(1, 6'b001010, 1, 4'h0, "jnz_z1", nop(0, 0), 0);
        e = st(0, 0, 0); e.pop = 1; e.s_stack_mux = 1;
        step(1, 6'b001100, 0, 4'h0, "ret", e, 0);

        // Two simultaneous requests: channel 1 first, channel 2 left pending.
        step(1, 6'b000001, 0, 4'h0, "ei", nop(0, 0), 0);
        step(1, 6'b000000, 0, 4'b0110, "req_edge", nop(1, 0), 1);
        e = nop(1, 0); e.vector_addr = 10'h3D0;
        step(1, 6'b000000, 0, 4'b0110, "pend_ch1", e, 1);
        step(1, 6'b010010, 0, 4'b0110, "take_ch1", tk(4'b0010, 10'h3D0), 1);
        e = nop(0, 1); e.vector_addr = 10'h3E0;
        step(1, 6'b000000, 0, 4'h0, "hdl1_pend2", e, 1);
        e = st(0, 1, 0); e.pop = 1; e.s_stack_mux = 1; e.s_return_intr = 1; e.vector_addr = 10'h3E0;
        step(1, 6'b001101, 0, 4'h0, "reti1", e, 1);
        e = nop(1, 0); e.we3 = 1; e.wez = 1; e.op_alu = 3'b010; e.vector_addr = 10'h3E0;
        step(1, 6'b010010, 0, 4'h0, "after_reti", e, 1);
        step(1, 6'b111111, 0, 4'h0, "take_ch2", tk(4'b0100, 10'h3E0), 1);
        e = st(0, 1, 0); e.pop = 1; e.s_stack_mux = 1; e.s_return_intr = 1;
        step(1, 6'b001101, 0, 4'h0, "reti2", e, 1);

        // HALT with interrupts disabled: only reset gets out.
        step(1, 6'b000010, 0, 4'h0, "di", nop(1, 0), 0);
        step(1, 6'b111111, 0, 4'h0, "halt_ie0", nop(0, 0), 0);
        for (int i = 0; i < 20; i++)
            step(1, 6'b000001, 0, (i == 3 || i == 10) ? 4'b1000 : 4'h0,
                 "halt_hold", st(0, 0, 1), 0);
        step(0, 6'b111111, 0, 4'h0, "reset_halt", st(0, 0, 0), 1);

        // HALT with interrupts enabled: channel 3 wakes it.
        step(1, 6'b000001, 0, 4'h0, "ei2", nop(0, 0), 1);
        step(1, 6'b111111, 0, 4'h0, "halt_ie1", nop(1, 0), 0);
        step(1, 6'b000000, 0, 4'b1000, "halt_req", st(1, 0, 1), 0);
        e = st(1, 0, 1); e.vector_addr = 10'h3F0;
        step(1, 6'b000000, 0, 4'b1000, "halt_pend", e, 1);
        step(1, 6'b000000, 0, 4'b1000, "take_ch3", tk(4'b1000, 10'h3F0), 1);
        step(1, 6'b000000, 0, 4'b1000, "hdl3", nop(0, 1), 1);
        e = st(0, 1, 0); e.pop = 1; e.s_stack_mux = 1; e.s_return_intr = 1;
        step(1, 6'b001101, 0, 4'b1000, "reti3", e, 1);
        // Request still held: no second capture.
        for (int i = 0; i < 6; i++)
            step(1, 6'b000000, 0, 4'b1000, "held_once", nop(1, 0), 1);

        // DI in the cycle the request becomes pending blocks the take.
        step(1, 6'b000000, 0, 4'h0, "idle", nop(1, 0), 1);
        step(1, 6'b000000, 0, 4'b0001, "req0_edge", nop(1, 0), 1);
        e = nop(1, 0); e.vector_addr = 10'h3C0;
        step(1, 6'b000010, 0, 4'b0001, "di_same", e, 1);
        e = nop(0, 0); e.vector_addr = 10'h3C0;
        step(1, 6'b000000, 0, 4'h0, "no_take1", e, 1);
        step(1, 6'b000000, 0, 4'h0, "no_take2", e, 1);
        step(1, 6'b000001, 0, 4'h0, "ei_take", e, 1);
        step(1, 6'b000000, 0, 4'h0, "take_ch0", tk(4'b0001, 10'h3C0), 1);
        step(1, 6'b000000, 0, 4'h0, "hdl0", nop(0, 1), 1);

        repeat (3) @(posedge clk);
        checks = checks + 1;
        if (q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL queue_drain left=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
